// File: rtl/instr_encoder.sv
// Program loader: encodes symbolic instruction requests into MIPS words and writes them to imem.
// Optional running XOR checksum of written words when INSTR_ENC_CKSUM_EN is defined.
//
// state | meaning
// IDLE  | ready for a request
// WRITE | imem_we high until the write completes (no stall)
// DONE  | program written or memory full; left only via clr/reset
module instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_class,
    input  logic              req_last,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              imem_stall,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   count,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [4:0]        SH        = 5'b0;

    state_t      state, state_nxt;
    logic        last_q;
    logic        accept;
    logic        write_ok;
    logic        illegal;
    logic [31:0] word_enc;

    assign illegal   = (req_class == 3'd7);
    assign req_ready = (state == IDLE) && reset;
    assign imem_we   = (state == WRITE);
    assign accept    = (state == IDLE) && req_valid && !clr;
    assign write_ok  = (state == WRITE) && !imem_stall && !clr;

    always_comb begin
        word_enc = '0;
        case (req_class)
            3'd0:    word_enc = {6'b000000, rs, rt, rd, SH, funct};
            3'd1:    word_enc = {6'b100011, rs, rt, imm};
            3'd2:    word_enc = {6'b100001, rs, rt, imm};
            3'd3:    word_enc = {6'b000100, rs, rt, imm};
            3'd4:    word_enc = {6'b001000, rs, rt, imm};
            3'd5:    word_enc = {6'b000010, target};
            3'd6:    word_enc = {6'b101010, rs, rt, rd, SH, 6'b101010};
            default: word_enc = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (req_valid && !illegal) state_nxt = WRITE;
                WRITE: if (!imem_stall)
                           state_nxt = (last_q || imem_addr == ADDR_MAX) ? DONE : IDLE;
                DONE:  state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_addr <= ADDR_BASE;
            imem_wd   <= '0;
            last_q    <= 1'b0;
            done      <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
        end else if (clr) begin
            imem_addr <= ADDR_BASE;
            last_q    <= 1'b0;
            done      <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            if (accept) begin
                if (illegal) begin
                    err <= 1'b1;
                end else begin
                    imem_wd <= word_enc;
                    last_q  <= req_last;
                end
            end
            if (write_ok) begin
                count     <= count + 1'b1;
                imem_addr <= imem_addr + 1'b1;   // wraps; FSM leaves for DONE at the top
                if (last_q)                done <= 1'b1;
                if (imem_addr == ADDR_MAX) full <= 1'b1;
            end
        end
    end

`ifdef INSTR_ENC_CKSUM_EN
    logic [31:0] cksum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        cksum_q <= '0;
        else if (clr)      cksum_q <= '0;
        else if (write_ok) cksum_q <= cksum_q ^ imem_wd;
    end

    assign checksum = cksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Program loader that produces the opcode stream consumed by the main control decoder.
- Accepts symbolic instruction requests (class plus fields) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word using the decoder's exact opcode table.
- Writes each word into instruction memory at consecutive word addresses, then signals completion.

Parameters:
- ADDR_W, 6: instruction memory word-address width (2^ADDR_W words).
- BASE_ADDR, 0: first word address written after reset or clr.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- clr  in  1  synchronous restart: back to IDLE, address to BASE_ADDR, flags cleared.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request this cycle.
- req_class  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J, 6=SLT, 7=illegal.
- req_last  in  1  this request is the final instruction of the program.
- rs, rt, rd  in  5 each  register fields.
- funct  in  6  R-class function code.
- imm  in  16  immediate for LW/SW/BEQ/ADDI.
- target  in  26  jump target for J.
- imem_stall  in  1  memory cannot accept a write this cycle.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wd  out  32  encoded instruction word.
- done  out  1  program fully written (sticky until clr or reset).
- full  out  1  last memory word written without req_last (sticky).
- err  out  1  illegal class received (sticky).
- count  out  ADDR_W+1  number of words written.
- checksum  out  32  see Optional Feature.

Behaviour:
- Reset (async, reset=0):
  - State = IDLE; imem_addr = BASE_ADDR.
  - imem_we, imem_wd, done, full, err, count, checksum = 0.
  - req_ready = 0 while reset is asserted.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - req_ready = 1.
  - Handshake occurs when req_valid & req_ready.
  - Legal class: encoded word is registered into imem_wd, req_last is captured, next state = WRITE.
  - Class 7: err set, nothing written, stay in IDLE.
- WRITE:
  - req_ready = 0; imem_we = 1.
  - If imem_stall: hold imem_we, imem_addr and imem_wd unchanged.
  - Else the write completes this cycle; on the next edge count increments and imem_addr increments.
  - Next state after a completed write: DONE (set done) if the captured last flag was set; DONE (set full) if imem_addr was 2^ADDR_W-1; otherwise IDLE.
  - If both conditions hold, set done and full together.
  - imem_addr wraps to 0 after 2^ADDR_W-1, but the FSM always leaves for DONE at that point.
- DONE:
  - req_ready = 0; imem_we = 0.
  - Exit only via clr or reset.
- Latency and throughput:
  - Handshake in cycle N; imem_we high in cycle N+1 when there is no stall.
  - Maximum throughput is 1 request per 2 cycles.
- clr:
  - Takes priority over every other transition in every state.
  - Next cycle: IDLE, address = BASE_ADDR, count/done/full/err/checksum = 0, imem_we = 0.
  - A write in progress is abandoned.
- Encoding, with sh = 5'b0 and fields concatenated MSB first:
  - R: 000000, rs, rt, rd, sh, funct.
  - LW: 100011, rs, rt, imm.
  - SW: 100001, rs, rt, imm.
  - BEQ: 000100, rs, rt, imm.
  - ADDI: 001000, rs, rt, imm.
  - J: 000010, target.
  - SLT: 101010, rs, rt, rd, sh, 101010.
  - Fields unused by a class are ignored.
- imem_wd retains its last value while imem_we = 0.

Optional Feature:
- Macro: INSTR_ENC_CKSUM_EN.
- Defined: checksum is a running XOR of every word actually written (each completed, non-stalled write); it is cleared by reset or clr.
- Undefined: checksum is tied to 0 and no XOR logic is built.

Test Plan:
- R: rs=1, rt=2, rd=3, funct=0x20 -> imem_we for 1 cycle, addr 0, wd 0x00221820, count=1, back to IDLE.
- LW: rs=2, rt=3, imm=0x0010, after the R above -> addr 1, wd 0x8C430010; with macro, checksum=0x8C611830.
- SW: rs=0, rt=5, imm=4, with imem_stall high for 3 cycles -> wd 0x84050004 and addr held 4 cycles, count increments once.
- J: target=0x10, req_last=1 -> wd 0x08000010, done=1, req_ready=0 thereafter; clr -> IDLE, addr 0, done=0.
- Class 7 -> err=1, no imem_we, req_ready stays 1; fill 64 legal requests with req_last=0 -> full=1 after addr 63, state DONE.
- Assert reset during WRITE -> imem_we falls immediately (asynchronously); after release: addr 0, count 0, IDLE.
